// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation and fetch control feeding decode.
// One-entry skid absorbs the memory's 1-cycle latency under stall.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic [31:0] mem_instr,
    output logic [31:0] mem_pc,
    output logic        mem_ena,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic        inflight;
    logic [31:0] inflight_pc;
    fetch_t      skid;
    logic        skid_valid;
    logic        out_free;
    logic        issue;
    logic        flush;

    assign out_free = !instr_valid || !stall;
    assign mem_pc   = pc;
    assign mem_ena  = issue;
    assign halted   = (state == HALT) && !inflight && !skid_valid;

    // Next state, next pc, and whether a fetch issues or a redirect flushes.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        issue    = 1'b0;
        flush    = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = halt_req ? HALT : RUN;
                if (branch_taken && !halt_req)
                    pc_nx = branch_target;
            end
            RUN: begin
                if (halt_req) begin
                    state_nx = HALT;
                end else if (branch_taken) begin
                    flush = 1'b1;
                    pc_nx = branch_target;
                end else if (!skid_valid && !(stall && instr_valid)) begin
                    issue = 1'b1;
                    pc_nx = pc + PC_INC;
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pc and tracking of the word currently in the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            inflight <= issue;
            if (issue)
                inflight_pc <= pc;
        end
    end

    // Output register and skid: skid drains before any newer word lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out   <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            skid        <= '0;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (skid_valid) begin
            if (out_free) begin
                instr_out   <= skid.instr;
                instr_pc    <= skid.pc;
                instr_valid <= 1'b1;
                skid_valid  <= 1'b0;
            end
        end else if (inflight) begin
            if (out_free) begin
                instr_out   <= mem_instr;
                instr_pc    <= inflight_pc;
                instr_valid <= 1'b1;
            end else begin
                skid.instr <= mem_instr;
                skid.pc    <= inflight_pc;
                skid_valid <= 1'b1;
            end
        end else if (out_free) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: queue-based fetch model checked every cycle,
// plus directed literal checks for startup, stall, branch, halt, reset, wrap.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt_req = 1'b0;
    logic [31:0] mem_instr = 32'h0;
    logic [31:0] mem_pc;
    logic        mem_ena;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;

    logic        rst2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = 32'h0;
    logic        halt2 = 1'b0;
    logic [31:0] mem_instr2 = 32'h0;
    logic [31:0] mem_pc2;
    logic        mem_ena2;
    logic [31:0] instr_out2;
    logic [31:0] instr_pc2;
    logic        instr_valid2;
    logic        halted2;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_INC  (32'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .mem_instr    (mem_instr),
        .mem_pc       (mem_pc),
        .mem_ena      (mem_ena),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    instr_fetch_unit #(
        .RESET_PC(32'hFFFF_FFFE),
        .PC_INC  (32'd1)
    ) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .stall        (stall2),
        .branch_taken (br2),
        .branch_target(tgt2),
        .halt_req     (halt2),
        .mem_instr    (mem_instr2),
        .mem_pc       (mem_pc2),
        .mem_ena      (mem_ena2),
        .instr_out    (instr_out2),
        .instr_pc     (instr_pc2),
        .instr_valid  (instr_valid2),
        .halted       (halted2)
    );

    // Instruction memories: 1-cycle read, contents A000_0000 + address.
    always @(posedge clk) if (mem_ena) mem_instr <= 32'hA000_0000 + mem_pc;
    always @(posedge clk) if (mem_ena2) mem_instr2 <= 32'hA000_0000 + mem_pc2;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Model: fetched words sit in a queue with an age; age 0 means the
    // memory is presenting the word now, age >= 1 means it waits in the skid.
    int          m_st = 0;
    logic [31:0] m_pc = 32'h0;
    bit          m_ov = 1'b0;
    logic [31:0] m_opc = 32'h0;
    logic [31:0] q_pc[$];
    int          q_age[$];

    function automatic bit m_skid();
        foreach (q_age[i]) if (q_age[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_issue();
        return (m_st == 1) && !m_skid() && !(stall && m_ov)
               && !branch_taken && !halt_req;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_st = 0;
                m_pc = 32'h0;
                m_ov = 1'b0;
                m_opc = 32'h0;
                q_pc.delete();
                q_age.delete();
            end else begin : step
                bit          iss;
                logic [31:0] npc;
                iss = m_issue();
                npc = m_pc;
                if (m_st == 1 && branch_taken && !halt_req) begin
                    q_pc.delete();
                    q_age.delete();
                    m_ov = 1'b0;
                    npc = branch_target;
                end else begin
                    if (!m_ov || !stall) begin
                        if (q_pc.size() > 0) begin
                            m_opc = q_pc.pop_front();
                            void'(q_age.pop_front());
                            m_ov = 1'b1;
                        end else begin
                            m_ov = 1'b0;
                        end
                    end
                    foreach (q_age[i]) q_age[i]++;
                    if (iss) begin
                        q_pc.push_back(m_pc);
                        q_age.push_back(0);
                        npc = m_pc + 32'd1;
                    end
                    if (m_st == 0 && branch_taken && !halt_req)
                        npc = branch_target;
                end
                m_pc = npc;
                if (m_st != 2 && halt_req) m_st = 2;
                else if (m_st == 0) m_st = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chkb("ena", mem_ena, m_issue());
            chk("mem_pc", mem_pc, m_pc);
            chkb("valid", instr_valid, m_ov);
            chkb("halted", halted, (m_st == 2) && (q_pc.size() == 0));
            if (m_ov) begin
                chk("instr_pc", instr_pc, m_opc);
                chk("instr_out", instr_out, 32'hA000_0000 + m_opc);
            end
        end
    end

    task automatic drive(input bit s, input bit b, input logic [31:0] t,
                         input bit h);
        stall = s;
        branch_taken = b;
        branch_target = t;
        halt_req = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        // startup
        drive(0, 0, 0, 0); chkb("idle_ena", mem_ena, 0); tick();
        for (int c = 1; c <= 5; c++) begin
            drive(0, 0, 0, 0);
            chk("start_pc", mem_pc, c - 1);
            chkb("start_ena", mem_ena, 1);
            chkb("start_vld", instr_valid, c >= 3);
            if (c >= 3) begin
                chk("start_ipc", instr_pc, c - 3);
                chk("start_out", instr_out, 32'hA000_0000 + c - 3);
            end
            tick();
        end
        // stall while word 3 is shown
        for (int c = 6; c <= 8; c++) begin
            drive(1, 0, 0, 0);
            chk("stall_ipc", instr_pc, 32'd3);
            chk("stall_out", instr_out, 32'hA000_0003);
            chkb("stall_ena", mem_ena, 0);
            tick();
        end
        drive(0, 0, 0, 0); chk("rel_ipc", instr_pc, 32'd3);
        chkb("rel_ena", mem_ena, 0); tick();
        drive(0, 0, 0, 0); chk("skid_ipc", instr_pc, 32'd4);
        chk("skid_pc", mem_pc, 32'd5); chkb("skid_ena", mem_ena, 1); tick();
        drive(0, 0, 0, 0); chkb("bubble", instr_valid, 0);
        chk("bub_pc", mem_pc, 32'd6); tick();
        drive(0, 0, 0, 0); chk("post5", instr_pc, 32'd5); tick();
        // branch while word 7 is in the memory
        drive(0, 1, 32'h40, 0); chk("post6", instr_pc, 32'd6);
        chkb("br_ena", mem_ena, 0); tick();
        drive(0, 0, 0, 0); chkb("br_vld", instr_valid, 0);
        chk("br_pc", mem_pc, 32'h40); chkb("br_ena2", mem_ena, 1); tick();
        drive(0, 0, 0, 0); chkb("br_vld2", instr_valid, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            chk("tgt_ipc", instr_pc, 32'h40 + k);
            chk("tgt_out", instr_out, 32'hA000_0040 + k);
            tick();
        end
        // halt in a steady stream
        drive(0, 0, 0, 1); chk("h_ipc", instr_pc, 32'h42);
        chkb("h_ena", mem_ena, 0); chkb("h_halted0", halted, 0); tick();
        drive(0, 0, 0, 0); chk("h_last", instr_pc, 32'h43);
        chkb("h_halted", halted, 1); chkb("h_ena2", mem_ena, 0); tick();
        drive(0, 1, 32'h99, 0); chkb("h_br_ena", mem_ena, 0); tick();
        drive(0, 0, 0, 0); chk("h_br_pc", mem_pc, 32'h44);
        chkb("h_vld", instr_valid, 0); tick();
        // restart, fill the skid under stall, then reset between edges
        rst = 1'b0; tick(); rst = 1'b1;
        for (int c = 0; c <= 3; c++) begin drive(0, 0, 0, 0); tick(); end
        drive(1, 0, 0, 0); chk("rs_ipc", instr_pc, 32'd1); tick();
        drive(1, 0, 0, 0); chk("rs_ipc2", instr_pc, 32'd1);
        chk("rs_pc", mem_pc, 32'd3);
        rst = 1'b0; #1;
        chkb("rs_vld", instr_valid, 0); chkb("rs_ena", mem_ena, 0);
        chkb("rs_halted", halted, 0); chk("rs_mpc", mem_pc, 32'h0);
        stall = 1'b0;
        tick(); tick(); rst = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            drive(0, 0, 0, 0);
            if (c >= 1) chk("rr_pc", mem_pc, c - 1);
            if (c >= 3) chk("rr_ipc", instr_pc, c - 3);
            tick();
        end
        // halt and branch together: branch ignored
        drive(0, 1, 32'h77, 1); chkb("hb_ena", mem_ena, 0);
        chk("hb_pc0", mem_pc, 32'd4); tick();
        drive(0, 0, 0, 0); chk("hb_pc", mem_pc, 32'd4);
        chk("hb_ipc", instr_pc, 32'd3); chkb("hb_halted", halted, 1); tick();
        drive(0, 0, 0, 0); chkb("hb_vld", instr_valid, 0);
        chk("hb_pc2", mem_pc, 32'd4); tick();
        // pc wrap on the second instance
        rst2 = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            logic [31:0] fp;
            logic [31:0] dp;
            fp = 32'hFFFF_FFFE + c - 1;
            dp = 32'hFFFF_FFFE + c - 3;
            if (c >= 1 && c <= 4) begin
                chk("wr_pc", mem_pc2, fp);
                chkb("wr_ena", mem_ena2, 1);
            end
            if (c >= 3) begin
                chk("wr_ipc", instr_pc2, dp);
                chk("wr_out", instr_out2, 32'hA000_0000 + dp);
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
